// File: rtl/uart_rx_axi_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_axi_buffer
// Purpose  : AXI4-Lite slave stage behind a UART receiver. Received bytes and
//            their parity/frame error flags are queued in a receive FIFO and
//            exposed through RX_BUFF (0x0), CONFIG (0x4) and STATUS (0x8).
//            A registered level interrupt signals data/threshold, errors and
//            (optionally) an idle timeout.
// Ports    : s_axi_aclk / s_axi_aresetn  clock, async active-low reset
//            rx_data, rx_new, rx_err_parity, rx_err_frame  receiver byte i/f
//            interrupt                   registered level interrupt
//            s_axi_*                     AXI4-Lite slave (prot/wstrb ignored)
// Options  : define UART_RX_TIMEOUT_EN to build the idle-timeout counter
//            (STATUS[5]); otherwise STATUS[5] reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_axi_buffer #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int BUFFER_SIZE        = 16,
    parameter int TIMEOUT_CYCLES     = 1000
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_new,
    input  logic                            rx_err_parity,
    input  logic                            rx_err_frame,
    output logic                            interrupt,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready
);

    localparam int       c_PTR_W       = $clog2(BUFFER_SIZE);
    localparam int       c_CNT_W       = c_PTR_W + 1;
    localparam bit [3:0] c_ADDR_RXBUF  = 4'h0;
    localparam bit [3:0] c_ADDR_CONFIG = 4'h4;
    localparam bit [3:0] c_ADDR_STATUS = 4'h8;
    localparam bit [1:0] c_OKAY        = 2'b00;
    localparam bit [1:0] c_SLVERR      = 2'b10;

    logic                          r_awready, r_bvalid, r_arready, r_rvalid, r_irq;
    logic [1:0]                    r_bresp, r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata, w_rdata;
    logic [9:0]                    r_mem [BUFFER_SIZE];
    logic [c_PTR_W-1:0]            r_wptr, r_rptr;
    logic [c_CNT_W-1:0]            r_count;
    logic                          r_ien_data, r_ien_err;
    logic [3:0]                    r_thr;
    logic                          r_ovr, r_par, r_frm, r_to;
    logic                          w_wr_hs, w_rd_hs, w_wr_ok, w_rd_ok, w_wr_cfg, w_st_clr;
    logic                          w_flush, w_pop, w_push, w_full, w_empty, w_ovr_evt, w_to_evt;
    logic [3:0]                    w_thr_eff;
    logic                          w_lvl;

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_awready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign interrupt     = r_irq;

    // Register select comes from bits [3:0]; any higher address bit set means
    // the access falls outside this 16-byte window and is rejected.
    assign w_wr_ok = (s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:4] == '0) &&
                     ((s_axi_awaddr[3:0] == c_ADDR_RXBUF) || (s_axi_awaddr[3:0] == c_ADDR_CONFIG) ||
                      (s_axi_awaddr[3:0] == c_ADDR_STATUS));
    assign w_rd_ok = (s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:4] == '0) &&
                     ((s_axi_araddr[3:0] == c_ADDR_RXBUF) || (s_axi_araddr[3:0] == c_ADDR_CONFIG) ||
                      (s_axi_araddr[3:0] == c_ADDR_STATUS));

    assign w_wr_hs  = r_awready & s_axi_awvalid & s_axi_wvalid;
    assign w_rd_hs  = r_arready & s_axi_arvalid;
    assign w_wr_cfg = w_wr_hs & w_wr_ok & (s_axi_awaddr[3:0] == c_ADDR_CONFIG);
    assign w_st_clr = w_rd_hs & w_rd_ok & (s_axi_araddr[3:0] == c_ADDR_STATUS);

    assign w_full    = (r_count == c_CNT_W'(BUFFER_SIZE));
    assign w_empty   = (r_count == '0);
    // Flush overrides everything else in its cycle: pop and push are both void.
    assign w_flush   = w_wr_cfg & s_axi_wdata[0];
    assign w_pop     = w_rd_hs & w_rd_ok & (s_axi_araddr[3:0] == c_ADDR_RXBUF) & ~w_empty & ~w_flush;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push    = rx_new & ~w_flush & (~w_full | w_pop);
    assign w_ovr_evt = rx_new & ~w_flush & w_full & ~w_pop;

`ifdef UART_RX_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    // Counts idle cycles while data waits; saturates so the event fires once.
    assign w_to_evt = ~w_empty & ~rx_new & ~w_pop & ~w_flush &
                      (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_to_cnt <= '0;
        end else if (rx_new || w_pop || w_flush || w_empty) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != 32'(TIMEOUT_CYCLES)) begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end
`else
    assign w_to_evt = 1'b0;
`endif

    // AXI write and read channels.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_OKAY;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_OKAY;
            r_rdata   <= '0;
        end else begin
            r_awready <= s_axi_awvalid & s_axi_wvalid & ~r_bvalid & ~r_awready;
            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? c_OKAY : c_SLVERR;
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
            r_arready <= s_axi_arvalid & ~r_rvalid & ~r_arready;
            if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
                r_rresp  <= w_rd_ok ? c_OKAY : c_SLVERR;
            end else if (r_rvalid && s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd_ok) begin
            case (s_axi_araddr[3:0])
                c_ADDR_RXBUF:  if (!w_empty) w_rdata = {1'b1, 21'b0, r_mem[r_rptr]};
                c_ADDR_CONFIG: w_rdata = {24'b0, r_thr, 1'b0, r_ien_err, r_ien_data, 1'b0};
                c_ADDR_STATUS: w_rdata = {15'b0, 9'(r_count), 2'b0, r_to, r_frm, r_par, r_ovr,
                                          w_full, w_empty};
                default:       w_rdata = '0;
            endcase
        end
    end

    // FIFO pointers, occupancy, configuration and sticky status.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ien_data <= 1'b0;
            r_ien_err  <= 1'b0;
            r_thr      <= '0;
            r_ovr      <= 1'b0;
            r_par      <= 1'b0;
            r_frm      <= 1'b0;
            r_to       <= 1'b0;
        end else begin
            if (w_flush) begin
                r_rptr  <= r_wptr;
                r_count <= '0;
            end else begin
                if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
                if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
                if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
                else if (w_pop && !w_push) r_count <= r_count - c_CNT_W'(1);
            end
            if (w_wr_cfg) begin
                r_ien_data <= s_axi_wdata[1];
                r_ien_err  <= s_axi_wdata[2];
                r_thr      <= s_axi_wdata[7:4];
            end
            // Read-to-clear loses to an event landing in the same cycle.
            r_ovr <= (r_ovr & ~w_st_clr) | w_ovr_evt;
            r_par <= (r_par & ~w_st_clr) | (rx_new & rx_err_parity);
            r_frm <= (r_frm & ~w_st_clr) | (rx_new & rx_err_frame);
            r_to  <= (r_to  & ~w_st_clr) | w_to_evt;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (w_push) r_mem[r_wptr] <= {rx_err_frame, rx_err_parity, rx_data};
    end

    assign w_thr_eff = (r_thr == 4'd0) ? 4'd1 : r_thr;
    assign w_lvl     = (16'(r_count) >= 16'(w_thr_eff));

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_ien_data & w_lvl) | (r_ien_err & (r_ovr | r_par | r_frm)) | (r_ien_data & r_to);
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                        s_axi_wdata[C_S_AXI_DATA_WIDTH-1:8], s_axi_wdata[3], (TIMEOUT_CYCLES > 0)};

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_axi_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_axi_buffer
// Purpose  : Self-checking bench for uart_rx_axi_buffer. A queue-based model
//            of the receive buffer predicts every read/write response and
//            the interrupt level; a monitor compares DUT responses as they
//            are accepted. Directed scenarios plus a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_axi_buffer;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_new = 1'b0, rx_err_parity = 1'b0, rx_err_frame = 1'b0;
    logic        irq;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic        bready = 1'b1, rready = 1'b1;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int failures = 0;
    bit rand_ready = 1'b0;

    // Model state: plain queue of {frame, parity, data} entries.
    logic [9:0]  mq[$];
    logic [33:0] rq[$];
    logic [1:0]  bq[$];
    bit          m_ovr, m_par, m_frm, m_ied, m_iee, m_irq_f;
    bit [3:0]    m_thr;

    always #5 clk = ~clk;

    uart_rx_axi_buffer #(.BUFFER_SIZE(N)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .rx_data(rx_data), .rx_new(rx_new), .rx_err_parity(rx_err_parity), .rx_err_frame(rx_err_frame),
        .interrupt(irq),
        .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(4'hF), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a[31:4] == 28'd0) && (a[3:0] == 4'h0 || a[3:0] == 4'h4 || a[3:0] == 4'h8);
    endfunction

    function automatic bit irq_fn();
        int thr;
        thr = (m_thr == 4'd0) ? 1 : int'(m_thr);
        return (m_ied && mq.size() >= thr) || (m_iee && (m_ovr || m_par || m_frm));
    endfunction

    // Reference model: one step per clock, evaluated from the inputs of the cycle.
    always @(negedge clk) begin : model
        bit rd, wr, flush, pop, full0, rd_ok, wr_ok;
        logic [31:0] exp;
        if (!rst_n) begin
            mq.delete(); rq.delete(); bq.delete();
            m_ovr = 0; m_par = 0; m_frm = 0; m_ied = 0; m_iee = 0; m_thr = 0; m_irq_f = 0;
        end else begin
            check("interrupt", 64'(irq), 64'(m_irq_f));
            m_irq_f = irq_fn();
            rd = arvalid && arready;
            wr = awvalid && wvalid && awready;
            rd_ok = addr_ok(araddr);
            wr_ok = addr_ok(awaddr);
            if (rd) begin
                exp = '0;
                if (rd_ok) begin
                    if (araddr[3:0] == 4'h0 && mq.size() > 0) exp = {1'b1, 21'b0, mq[0]};
                    if (araddr[3:0] == 4'h4) exp = {24'b0, m_thr, 1'b0, m_iee, m_ied, 1'b0};
                    if (araddr[3:0] == 4'h8)
                        exp = {15'b0, 9'(mq.size()), 3'b0, m_frm, m_par, m_ovr, mq.size() == N, mq.size() == 0};
                end
                rq.push_back({rd_ok ? 2'b00 : 2'b10, exp});
            end
            if (wr) bq.push_back(wr_ok ? 2'b00 : 2'b10);
            flush = wr && wr_ok && awaddr[3:0] == 4'h4 && wdata[0];
            pop   = rd && rd_ok && araddr[3:0] == 4'h0 && mq.size() > 0 && !flush;
            full0 = (mq.size() == N);
            if (rd && rd_ok && araddr[3:0] == 4'h8) begin m_ovr = 0; m_par = 0; m_frm = 0; end
            if (wr && wr_ok && awaddr[3:0] == 4'h4) begin
                m_ied = wdata[1]; m_iee = wdata[2]; m_thr = wdata[7:4];
            end
            if (flush) mq.delete();
            if (pop) void'(mq.pop_front());
            if (rx_new) begin
                if (rx_err_parity) m_par = 1;
                if (rx_err_frame) m_frm = 1;
                if (!flush) begin
                    if (!full0 || pop) mq.push_back({rx_err_frame, rx_err_parity, rx_data});
                    else m_ovr = 1;
                end
            end
        end
    end

    // Monitor: compares each accepted response against the oldest prediction.
    always @(negedge clk) begin : monitor
        logic [33:0] e;
        if (rst_n) begin
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL r_unexpected actual=rvalid required=no response at %0t", $time);
                end else begin
                    e = rq.pop_front();
                    check("rdata", 64'(rdata), 64'(e[31:0]));
                    check("rresp", 64'(rresp), 64'(e[33:32]));
                end
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected actual=bvalid required=no response at %0t", $time);
                end else begin
                    check("bresp", 64'(bresp), 64'(bq.pop_front()));
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        bready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit p, input bit f);
        rx_data = d; rx_err_parity = p; rx_err_frame = f; rx_new = 1'b1;
        tick();
        rx_new = 1'b0; rx_err_parity = 1'b0; rx_err_frame = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a);
        int n = 0;
        bit hs = 0;
        araddr = a; arvalid = 1'b1;
        do begin
            @(negedge clk); hs = arready;
            tick(); n++;
        end while (!hs && n < 60);
        arvalid = 1'b0;
        if (!hs) begin
            checks++; failures++;
            $display("FAIL ar_handshake actual=no arready required=arready within 60 cycles");
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        bit hs = 0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        do begin
            @(negedge clk); hs = awready;
            tick(); n++;
        end while (!hs && n < 60);
        awvalid = 1'b0; wvalid = 1'b0;
        if (!hs) begin
            checks++; failures++;
            $display("FAIL aw_handshake actual=no awready required=awready within 60 cycles");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0 || rvalid || bvalid) && n < 200) begin
            tick(); n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL idle_wait actual=responses pending required=drained within 200 cycles");
        end
        tick();
    endtask

    // Starts a read and drives rx_new exactly in the address-handshake cycle.
    task automatic read_with_push(input logic [31:0] a, input logic [7:0] d);
        araddr = a; arvalid = 1'b1;
        tick();
        rx_data = d; rx_new = 1'b1;
        tick();
        arvalid = 1'b0; rx_new = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] v;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, irq, rdata},
              64'd0);
        #4 rst_n = 1'b1;
        tick();
        // Reset status, single byte round trip.
        axi_read(32'h8);
        push(8'hAA, 0, 0);
        axi_read(32'h0);
        axi_read(32'h8);
        wait_idle();
        // Overfill: 17 pushes into 16 entries, drain 16 + 1 empty read.
        for (int i = 0; i < 17; i++) push(8'(i), 0, 0);
        axi_read(32'h8);
        for (int i = 0; i < 17; i++) axi_read(32'h0);
        axi_read(32'h8);
        wait_idle();
        // Threshold interrupt.
        axi_write(32'h4, 32'h32);
        push(8'h01, 0, 0); push(8'h02, 0, 0);
        repeat (3) tick();
        push(8'h03, 0, 0);
        repeat (3) tick();
        axi_read(32'h0);
        wait_idle();
        // Error interrupt and frame flag in the entry.
        axi_write(32'h4, 32'h04);
        axi_write(32'h4, 32'h01);
        push(8'h55, 0, 1);
        repeat (3) tick();
        axi_read(32'h0);
        repeat (3) tick();
        axi_read(32'h8);
        wait_idle();
        // Out-of-range accesses and a rejected aliasing address.
        axi_read(32'hC);
        axi_write(32'h10, 32'hFF);
        axi_write(32'h8, 32'hFF);
        axi_read(32'h4);
        axi_read(32'h8);
        wait_idle();
        // Flush with a push in the handshake cycle.
        push(8'h11, 0, 0); push(8'h22, 0, 0); push(8'h33, 0, 0);
        rx_data = 8'h77; rx_new = 1'b1;
        axi_write(32'h4, 32'h01);
        rx_new = 1'b0;
        axi_read(32'h8);
        wait_idle();
        // Empty FIFO: read and push together; full FIFO: pop and push together.
        read_with_push(32'h0, 8'h9C);
        wait_idle();
        axi_read(32'h8);
        for (int i = 0; i < N - 1; i++) push(8'(8'h40 + i), 1'(i[0]), 0);
        wait_idle();
        read_with_push(32'h0, 8'hE1);
        wait_idle();
        axi_read(32'h8);
        axi_read(32'h0);
        wait_idle();
        // Randomized traffic with random back-pressure.
        rand_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    rx_data = 8'($urandom);
                    rx_err_parity = ($urandom_range(0, 7) == 0);
                    rx_err_frame = ($urandom_range(0, 7) == 0);
                    rx_new = ($urandom_range(0, 2) == 0);
                    tick();
                end
                rx_new = 1'b0; rx_err_parity = 1'b0; rx_err_frame = 1'b0;
            end
            begin
                for (int i = 0; i < 70; i++) begin
                    int sel;
                    sel = int'($urandom_range(0, 9));
                    if (sel < 5) axi_read(32'h0);
                    else if (sel < 7) axi_read(32'h8);
                    else if (sel == 7) axi_read(32'h4);
                    else if (sel == 8) begin
                        v = 32'($urandom_range(0, 255));
                        if ($urandom_range(0, 5) != 0) v[0] = 1'b0;
                        axi_write(32'h4, v);
                    end else axi_read(32'hC);
                    repeat ($urandom_range(0, 3)) tick();
                end
            end
        join
        rand_ready = 1'b0;
        wait_idle();
        // Reset in the middle of a read handshake: no response may follow.
        wait_idle();
        araddr = 32'h8; arvalid = 1'b1;
        tick();
        rst_n = 1'b0;
        tick(); tick();
        arvalid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_no_resp", {62'd0, rvalid, bvalid}, 64'd0);
        end
        tick();
        axi_read(32'h8);
        wait_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
